// File: rtl/seq_multiplier_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
// Define SEQ_MULT_EARLY_TERM_EN to stop CALC once no multiplier bits remain.
package seq_multiplier_pkg;

  localparam int DEF_WIDTH = 4;

`ifdef SEQ_MULT_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mult_dp.sv
// Multiplier datapath: accumulator, shifting multiplicand and multiplier.
// Exposes this step's accumulator result so the final add is never lost.
module seq_mult_dp
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_nxt_o,
  output logic               mplier_zero_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  assign acc_nxt_o = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign mplier_zero_o = ((mplier_q >> 1) == '0);

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    unique case (1'b1)
      load_i: begin
        acc_d    = '0;
        mcand_d  = {{WIDTH{1'b0}}, a_i};
        mplier_d = b_i;
      end
      step_i: begin
        acc_d    = acc_nxt_o;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential unsigned multiplier: FSM, iteration counter, product register.
// Early termination is selected by SEQ_MULT_EARLY_TERM_EN (see package).
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               load, step, last;
  logic [2*WIDTH-1:0] acc_nxt;
  logic               mplier_zero;

  seq_mult_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (load),
    .step_i       (step),
    .a_i          (a),
    .b_i          (b),
    .acc_nxt_o    (acc_nxt),
    .mplier_zero_o(mplier_zero)
  );

  assign last = (cnt_q == CNT_W'(WIDTH - 1)) || (EARLY_TERM && mplier_zero);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        step  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          prod_d  = acc_nxt;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Accepting start here gives back-to-back operation.
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign busy    = (state_q == S_CALC);
  assign done    = (state_q == S_DONE);
  assign product = prod_q;

endmodule
